// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer
// Description : Ordered reset-release controller behind the PLL/clock block.
//               It qualifies PLL lock, then releases the SDRAM, core and
//               display resets in order, with guard gaps between releases.
//               It waits for the SDRAM init handshake, with a timeout. It
//               re-sequences on lock loss or on a software reset request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_sys         in   system clock, the only clock of this block
//   rst_n           in   asynchronous active-low reset
//   pll_locked      in   PLL lock (asynchronous), double-flopped internally
//   sdram_init_done in   SDRAM controller init complete (level)
//   soft_rst_req    in   single-cycle pulse, restarts the sequence
//   rst_n_sdram     out  SDRAM controller reset, active-low
//   rst_n_core      out  core datapath reset, active-low
//   rst_n_disp      out  display/interface reset, active-low
//   seq_done        out  high while in RUN
//   seq_err         out  high while in FAULT
//   seq_state       out  current state encoding (debug)
//   lock_loss_cnt   out  saturating count of lock losses after WAIT_LOCK
// ============================================================================
module rst_sequencer #(
  parameter int LOCK_WAIT   = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int ACK_TIMEOUT = 65535,
  parameter int CNT_W       = 16
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  input  logic       soft_rst_req,
  output logic       rst_n_sdram,
  output logic       rst_n_core,
  output logic       rst_n_disp,
  output logic       seq_done,
  output logic       seq_err,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_REL_SDRAM = 3'd2,
    S_WAIT_INIT = 3'd3,
    S_REL_CORE  = 3'd4,
    S_REL_DISP  = 3'd5,
    S_RUN       = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  // Exit compares are made against N-1. The counter starts at 0 on state
  // entry, so the transition lands on the N-th cycle in the state.
  localparam logic [CNT_W-1:0] c_LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] c_ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             locked_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       llc_q, llc_d;
  logic             in_released;
  logic             rst_n_sdram_q, rst_n_core_q, rst_n_disp_q;
  logic             seq_done_q, seq_err_q;

  assign locked_s    = sync2_q;
  assign in_released = (state_q >= S_REL_SDRAM) && (state_q <= S_RUN);
  // The shared counter saturates instead of wrapping.
  assign cnt_inc     = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + c_CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    llc_d   = llc_q;
    if (soft_rst_req) begin
      // A software restart outranks lock loss. It does not count as a loss.
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
    end else if (!locked_s && in_released) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
        S_WAIT_LOCK: begin
          if (!locked_s) begin
            cnt_d = '0;
          end else if (cnt_q == c_LOCK_LAST) begin
            state_d = S_REL_SDRAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_REL_SDRAM, S_REL_CORE, S_REL_DISP: begin
          if (cnt_q == c_GAP_LAST) begin
            cnt_d = '0;
            case (state_q)
              S_REL_SDRAM: state_d = S_WAIT_INIT;
              S_REL_CORE:  state_d = S_REL_DISP;
              default:     state_d = S_RUN;
            endcase
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT_INIT: begin
          // When init done and the timeout land in the same cycle, init done wins.
          if (sdram_init_done) begin
            state_d = S_REL_CORE;
            cnt_d   = '0;
          end else if (cnt_q == c_ACK_LAST) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_RUN:   state_d = S_RUN;
        // FAULT ignores lock loss. Only soft_rst_req (handled above) leaves it.
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The outputs decode the next state, so they change on the same edge as the
  // state register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      llc_q         <= 8'd0;
      rst_n_sdram_q <= 1'b0;
      rst_n_core_q  <= 1'b0;
      rst_n_disp_q  <= 1'b0;
      seq_done_q    <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      sync1_q       <= pll_locked;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      llc_q         <= llc_d;
      rst_n_sdram_q <= (state_d >= S_REL_SDRAM) && (state_d <= S_RUN);
      rst_n_core_q  <= (state_d >= S_REL_CORE)  && (state_d <= S_RUN);
      rst_n_disp_q  <= (state_d >= S_REL_DISP)  && (state_d <= S_RUN);
      seq_done_q    <= (state_d == S_RUN);
      seq_err_q     <= (state_d == S_FAULT);
    end
  end

  assign rst_n_sdram   = rst_n_sdram_q;
  assign rst_n_core    = rst_n_core_q;
  assign rst_n_disp    = rst_n_disp_q;
  assign seq_done      = seq_done_q;
  assign seq_err       = seq_err_q;
  assign seq_state     = state_q;
  assign lock_loss_cnt = llc_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_sequencer
// Description : Directed testbench for rst_sequencer. It runs with
//               LOCK_WAIT=8, STAGE_GAP=4 and ACK_TIMEOUT=32. Each expected
//               value is hand-computed from the state rules, counting clock
//               edges from the input change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sdram_init_done;
  logic       soft_rst_req;
  logic       rst_n_sdram, rst_n_core, rst_n_disp;
  logic       seq_done, seq_err;
  logic [2:0] seq_state;
  logic [7:0] lock_loss_cnt;

  int n_total = 0;
  int n_bad   = 0;

  rst_sequencer #(
    .LOCK_WAIT   (8),
    .STAGE_GAP   (4),
    .ACK_TIMEOUT (32),
    .CNT_W       (16)
  ) u_dut (
    .clk_sys         (clk_sys),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .sdram_init_done (sdram_init_done),
    .soft_rst_req    (soft_rst_req),
    .rst_n_sdram     (rst_n_sdram),
    .rst_n_core      (rst_n_core),
    .rst_n_disp      (rst_n_disp),
    .seq_done        (seq_done),
    .seq_err         (seq_err),
    .seq_state       (seq_state),
    .lock_loss_cnt   (lock_loss_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Pack {sdram,core,disp,done,err} into one value so a single check covers them.
  function automatic logic [31:0] outs();
    return {27'd0, rst_n_sdram, rst_n_core, rst_n_disp, seq_done, seq_err};
  endfunction

  initial begin
    rst_n           = 1'b0;
    pll_locked      = 1'b1;
    sdram_init_done = 1'b0;
    soft_rst_req    = 1'b0;
    step(2);
    check("reset_outs",  outs(),        32'b00000);
    check("reset_state", seq_state,     32'd0);
    check("reset_llc",   lock_loss_cnt, 32'd0);

    // ---------------- nominal sequence ----------------
    rst_n = 1'b1;
    step(1);                                      // E1: IDLE -> WAIT_LOCK
    check("nom_wait_lock", seq_state, 32'd1);
    step(1);                                      // E2: locked_s rises
    step(7);                                      // E9
    check("nom_sdram_early", rst_n_sdram, 32'd0);
    step(1);                                      // E10: 8 after locked_s rise
    check("nom_sdram_rel", outs(), 32'b10000);
    check("nom_st_rel_sdram", seq_state, 32'd2);
    step(4);                                      // E14
    check("nom_wait_init", seq_state, 32'd3);
    step(6);                                      // E20: 10 after sdram rise
    check("nom_still_wait", seq_state, 32'd3);
    sdram_init_done = 1'b1;
    step(1);                                      // E21
    check("nom_core_rel", outs(), 32'b11000);
    step(3);
    check("nom_disp_early", rst_n_disp, 32'd0);
    step(1);                                      // E25
    check("nom_disp_rel", outs(), 32'b11100);
    step(4);                                      // E29
    check("nom_run_outs", outs(), 32'b11110);
    check("nom_run_state", seq_state, 32'd6);

    // ---------------- lock loss in RUN ----------------
    pll_locked = 1'b0;
    step(2);
    check("loss_lat2", rst_n_sdram, 32'd1);
    step(1);                                      // third edge
    check("loss_outs", outs(), 32'b00000);
    check("loss_state", seq_state, 32'd1);
    check("loss_llc", lock_loss_cnt, 32'd1);
    pll_locked = 1'b1;
    step(9);
    check("relock_early", rst_n_sdram, 32'd0);
    step(1);                                      // E10
    check("relock_sdram", rst_n_sdram, 32'd1);
    step(5);                                      // E15: init already done
    check("relock_core", seq_state, 32'd4);
    step(8);                                      // E23
    check("relock_run", outs(), 32'b11110);

    // ---------------- lock glitch, then timeout ----------------
    rst_n           = 1'b0;
    pll_locked      = 1'b0;
    sdram_init_done = 1'b0;
    #1;
    check("rst2_outs", outs(), 32'b00000);
    check("rst2_llc",  lock_loss_cnt, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);                                      // E1
    pll_locked = 1'b1;
    step(5);                                      // E6
    pll_locked = 1'b0;
    step(1);                                      // E7
    pll_locked = 1'b1;
    step(9);                                      // E16
    check("glitch_early", rst_n_sdram, 32'd0);
    step(1);                                      // E17: 8 after second rise
    check("glitch_sdram", rst_n_sdram, 32'd1);
    check("glitch_llc", lock_loss_cnt, 32'd0);
    step(4);                                      // WAIT_INIT entry
    check("to_wait_init", seq_state, 32'd3);
    step(31);
    check("to_before", seq_state, 32'd3);
    step(1);                                      // 32 into WAIT_INIT
    check("to_fault_state", seq_state, 32'd7);
    check("to_fault_outs", outs(), 32'b00001);
    pll_locked = 1'b0;
    step(5);
    check("fault_ign_loss", seq_state, 32'd7);
    check("fault_llc", lock_loss_cnt, 32'd0);
    soft_rst_req = 1'b1;
    pll_locked   = 1'b1;
    step(1);                                      // E1
    soft_rst_req = 1'b0;
    check("soft_state", seq_state, 32'd1);
    check("soft_err", seq_err, 32'd0);
    sdram_init_done = 1'b1;
    step(8);                                      // E9
    check("soft_early", rst_n_sdram, 32'd0);
    step(1);                                      // E10
    check("soft_sdram", rst_n_sdram, 32'd1);
    step(13);                                     // E23
    check("soft_run", outs(), 32'b11110);

    // ---------------- soft request coincides with lock loss ----------------
    pll_locked = 1'b0;
    step(2);
    check("sim_still_run", seq_state, 32'd6);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    check("sim_state", seq_state, 32'd1);
    check("sim_llc", lock_loss_cnt, 32'd0);

    // ---------------- lock-loss counter saturation ----------------
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      step(10);                                   // reaches REL_SDRAM
      pll_locked = 1'b0;
      step(3);                                    // loss taken
      if (i == 0) check("sat_first", lock_loss_cnt, 32'd1);
      if (i == 1) check("sat_second", lock_loss_cnt, 32'd2);
    end
    check("sat_llc", lock_loss_cnt, 32'd255);

    // ---------------- async reset during REL_CORE ----------------
    pll_locked = 1'b1;
    step(15);                                     // E15
    check("arst_in_core", seq_state, 32'd4);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs",  outs(),        32'b00000);
    check("arst_state", seq_state,     32'd0);
    check("arst_llc",   lock_loss_cnt, 32'd0);
    #1;
    rst_n = 1'b1;
    step(1);                                      // E1
    check("arst_restart", seq_state, 32'd1);
    step(8);                                      // E9
    check("arst_early", rst_n_sdram, 32'd0);
    step(1);                                      // E10
    check("arst_sdram", rst_n_sdram, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
